// File: rtl/coin_conditioner_pkg.sv
// Shared coin constants and helpers for the coin conditioner and the downstream vend stage.
// Credit values are held CREDIT_W bits wide; sums are formed one bit wider.
package coin_conditioner_pkg;

   localparam int unsigned CREDIT_W                = 6;
   localparam int unsigned SUM_W                   = CREDIT_W + 1;
   localparam int unsigned NICKEL_CENTS            = 5;
   localparam int unsigned DIME_CENTS              = 10;
   localparam int unsigned QUARTER_CENTS           = 25;
   localparam int unsigned DEFAULT_MAX_CREDIT      = 45;
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

   typedef logic [CREDIT_W-1:0] cents_t;

   typedef enum logic [1:0] {
      CoinNone,
      CoinNickel,
      CoinDime,
      CoinQuarter
   } coin_e;

   typedef struct packed {
      logic quarter;
      logic dime;
      logic nickel;
   } press_t;

   // Highest-value coin wins when several presses land on the same cycle.
   function automatic coin_e coin_pick(press_t p);
      coin_e c;
      if (p.quarter) begin
         c = CoinQuarter;
      end else if (p.dime) begin
         c = CoinDime;
      end else if (p.nickel) begin
         c = CoinNickel;
      end else begin
         c = CoinNone;
      end
      return c;
   endfunction

   function automatic cents_t coin_cents(coin_e c);
      cents_t v;
      unique case (c)
         CoinNickel:  v = cents_t'(NICKEL_CENTS);
         CoinDime:    v = cents_t'(DIME_CENTS);
         CoinQuarter: v = cents_t'(QUARTER_CENTS);
         default:     v = '0;
      endcase
      return v;
   endfunction

   // True when more than one press is present, i.e. there are collision losers.
   function automatic logic press_collision(press_t p);
      return (p.quarter & (p.dime | p.nickel)) | (p.dime & p.nickel);
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin switch channel: 2-flop synchronizer, stability counter, debounced level and a
// registered single-cycle pulse on each debounced 0->1 transition.
module coin_debounce
   import coin_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic raw_i,
   output logic press_o
);

   localparam int unsigned        CntW    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0]    CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            level_q, level_d;
   logic            level_dly_q;
   logic            press_q, press_d;

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntLast) begin
         // This is the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
         cnt_d   = '0;
         level_d = sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      press_d = level_q & ~level_dly_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
      end else begin
         sync1_q     <= raw_i;
         sync2_q     <= sync1_q;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         level_dly_q <= level_q;
         press_q     <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/coin_conditioner.sv
// Coin input conditioner: debounces three coin switches, resolves simultaneous presses,
// applies the credit ceiling and keeps the running credit for the vend stage.
module coin_conditioner
   import coin_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned MAX_CREDIT      = DEFAULT_MAX_CREDIT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                nickels,
   input  logic                dimes,
   input  logic                quarters,
   input  logic                clear_credit,
   output logic                coin_valid,
   output logic [CREDIT_W-1:0] coin_value,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit
);

   localparam logic [SUM_W-1:0] MaxCreditW = SUM_W'(MAX_CREDIT);

   logic       nickel_press, dime_press, quarter_press;
   press_t     press;
   coin_e      winner;
   cents_t     win_cents;
   cents_t     base;
   logic [SUM_W-1:0] sum;
   logic       fits;
   logic       any_press;

   logic       valid_q, valid_d;
   logic       reject_q, reject_d;
   cents_t     value_q, value_d;
   cents_t     credit_q, credit_d;

   coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_nickel (
      .clk_i  (clk),
      .reset_i(reset),
      .raw_i  (nickels),
      .press_o(nickel_press)
   );

   coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_dime (
      .clk_i  (clk),
      .reset_i(reset),
      .raw_i  (dimes),
      .press_o(dime_press)
   );

   coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_quarter (
      .clk_i  (clk),
      .reset_i(reset),
      .raw_i  (quarters),
      .press_o(quarter_press)
   );

   always_comb begin
      press     = '{quarter: quarter_press, dime: dime_press, nickel: nickel_press};
      winner    = coin_pick(press);
      win_cents = coin_cents(winner);
      any_press = (winner != CoinNone);
      // A clear on the same cycle as a coin means the coin starts a fresh credit.
      base      = clear_credit ? '0 : credit_q;
      sum       = {1'b0, base} + {1'b0, win_cents};
      fits      = (sum <= MaxCreditW);
      valid_d   = any_press & fits;
      reject_d  = any_press & (~fits | press_collision(press));
      value_d   = valid_d ? win_cents : '0;
      credit_d  = valid_d ? sum[CREDIT_W-1:0] : base;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         reject_q <= 1'b0;
         value_q  <= '0;
         credit_q <= '0;
      end else begin
         valid_q  <= valid_d;
         reject_q <= reject_d;
         value_q  <= value_d;
         credit_q <= credit_d;
      end
   end

   assign coin_valid  = valid_q;
   assign coin_reject = reject_q;
   assign coin_value  = value_q;
   assign credit      = credit_q;

endmodule

// File: tb/tb_coin_conditioner.sv
// Scoreboard bench for coin_conditioner: a per-edge reference model queues expected coin
// events, and a negedge monitor checks every DUT event, the credit and reset behaviour.
module tb_coin_conditioner;
   import coin_conditioner_pkg::*;

   localparam int unsigned D    = 4;
   localparam int unsigned MAXC = 45;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       nickels = 1'b0, dimes = 1'b0, quarters = 1'b0, clear_credit = 1'b0;
   logic       coin_valid, coin_reject;
   logic [5:0] coin_value, credit;

   int chk = 0;
   int err = 0;

   always #5 clk = ~clk;

   coin_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .MAX_CREDIT     (MAXC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .nickels     (nickels),
      .dimes       (dimes),
      .quarters    (quarters),
      .clear_credit(clear_credit),
      .coin_valid  (coin_valid),
      .coin_value  (coin_value),
      .coin_reject (coin_reject),
      .credit      (credit)
   );

   typedef struct {
      int edge_no;
      bit valid;
      int value;
      bit reject;
      int credit;
   } exp_t;

   exp_t exp_q[$];

   task automatic cmp(string name, int act, int exp);
      chk++;
      if (act != exp) begin
         err++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: a coin is accepted once the sampled raw level has differed from the
   // accepted level for D consecutive samples; its result appears 4 edges after that sample.
   int  cyc = 0;
   bit  m_live = 0;
   bit  m_rst = 1;
   int  m_credit = 0;
   bit  lvl[3], last[3];
   int  run[3];
   int  sched[5];
   int  cents[3] = '{NICKEL_CENTS, DIME_CENTS, QUARTER_CENTS};

   always @(posedge clk) begin
      bit   raw[3];
      int   cur, base, win, npress;
      exp_t e;
      cyc++;
      m_live = 1;
      if (reset) begin
         m_rst    = 1;
         m_credit = 0;
         for (int i = 0; i < 3; i++) begin
            lvl[i] = 0; last[i] = 0; run[i] = 0;
         end
         for (int j = 0; j < 5; j++) sched[j] = 0;
      end else begin
         m_rst = 0;
         cur = sched[0];
         for (int j = 0; j < 4; j++) sched[j] = sched[j+1];
         sched[4] = 0;
         base = clear_credit ? 0 : m_credit;
         if (cur != 0) begin
            win    = cur[2] ? 2 : (cur[1] ? 1 : 0);
            npress = int'(cur[0]) + int'(cur[1]) + int'(cur[2]);
            if (base + cents[win] <= MAXC) begin
               e.valid  = 1;
               e.value  = cents[win];
               e.reject = (npress > 1);
               m_credit = base + cents[win];
            end else begin
               e.valid  = 0;
               e.value  = 0;
               e.reject = 1;
               m_credit = base;
            end
            e.edge_no = cyc;
            e.credit  = m_credit;
            exp_q.push_back(e);
         end else begin
            m_credit = base;
         end
         raw = '{nickels, dimes, quarters};
         for (int i = 0; i < 3; i++) begin
            run[i]  = (raw[i] == last[i]) ? run[i] + 1 : 1;
            last[i] = raw[i];
            if (raw[i] != lvl[i] && run[i] >= int'(D)) begin
               lvl[i] = raw[i];
               if (raw[i]) sched[3] = sched[3] | (1 << i);
            end
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (m_live) begin
         if (m_rst) begin
            cmp("reset_outputs", int'({coin_valid, coin_reject, coin_value, credit}), 0);
         end else begin
            cmp("credit", int'(credit), m_credit);
            while (exp_q.size() > 0 && exp_q[0].edge_no < cyc) begin
               e = exp_q.pop_front();
               cmp("missed_event_edge", cyc, e.edge_no);
            end
            if (coin_valid || coin_reject) begin
               if (exp_q.size() == 0) begin
                  cmp("unexpected_event", int'({coin_valid, coin_reject}), 0);
               end else begin
                  e = exp_q.pop_front();
                  cmp("event_edge", cyc, e.edge_no);
                  cmp("coin_valid", int'(coin_valid), int'(e.valid));
                  cmp("coin_value", int'(coin_value), e.value);
                  cmp("coin_reject", int'(coin_reject), int'(e.reject));
               end
            end else if (coin_value != 0) begin
               cmp("idle_coin_value", int'(coin_value), 0);
            end
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_coin(int ch, logic v);
      case (ch)
         0:       nickels = v;
         1:       dimes = v;
         default: quarters = v;
      endcase
   endtask

   task automatic insert(int ch);
      set_coin(ch, 1'b1);
      tick(10);
      set_coin(ch, 1'b0);
      tick(10);
   endtask

   task automatic clear_pulse();
      clear_credit = 1'b1;
      tick(1);
      clear_credit = 1'b0;
      tick(2);
   endtask

   initial begin
      tick(3);
      cmp("reset_credit", int'(credit), 0);
      cmp("reset_valid", int'(coin_valid), 0);
      reset = 1'b0;
      tick(2);

      // Single held quarter
      quarters = 1'b1;
      tick(20);
      quarters = 1'b0;
      tick(10);
      cmp("quarter_credit", int'(credit), 25);
      clear_pulse();
      cmp("clear_credit", int'(credit), 0);

      // Bouncing dime shorter than the debounce window
      for (int i = 0; i < 10; i++) begin
         dimes = ~dimes;
         tick(2);
      end
      tick(10);
      cmp("bounce_credit", int'(credit), 0);

      // Fill to the ceiling, then overflow
      insert(2);
      cmp("seq_credit_q", int'(credit), 25);
      insert(1);
      cmp("seq_credit_d1", int'(credit), 35);
      insert(1);
      cmp("seq_credit_d2", int'(credit), 45);
      insert(0);
      cmp("overflow_credit", int'(credit), 45);
      clear_pulse();

      // Nickel and quarter collide
      nickels  = 1'b1;
      quarters = 1'b1;
      tick(12);
      nickels  = 1'b0;
      quarters = 1'b0;
      tick(10);
      cmp("collision_credit", int'(credit), 25);
      clear_pulse();

      // Clear on the same cycle as a dime event
      insert(2);
      insert(1);
      insert(0);
      cmp("forty_credit", int'(credit), 40);
      dimes = 1'b1;
      tick(7);
      clear_credit = 1'b1;
      tick(1);
      clear_credit = 1'b0;
      cmp("clear_dime_valid", int'(coin_valid), 1);
      cmp("clear_dime_credit", int'(credit), 10);
      tick(4);
      dimes = 1'b0;
      tick(10);
      clear_pulse();

      // Reset in the middle of a dime debounce, dime still held
      dimes = 1'b1;
      tick(2);
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(12);
      cmp("post_reset_credit", int'(credit), 10);
      dimes = 1'b0;
      tick(10);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(5) == 0) nickels = ~nickels;
         if ($urandom_range(5) == 0) dimes = ~dimes;
         if ($urandom_range(5) == 0) quarters = ~quarters;
         clear_credit = ($urandom_range(24) == 0);
         reset        = ($urandom_range(399) == 0);
         tick(1);
      end
      reset        = 1'b0;
      clear_credit = 1'b0;
      nickels      = 1'b0;
      dimes        = 1'b0;
      quarters     = 1'b0;
      tick(20);
      cmp("drain_queue", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
